// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 6502 bus arbiter: CPU BE control, round-robin master grant, turnaround gaps
// Optional tenure limit enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int TURN     = 2,
  parameter int MAX_HOLD = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cycle_strobe,
  input  logic            mlock_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            busen,
  output logic            bus_idle,
  output logic            timeout_err
);

  localparam int         PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] TURN_MAX  = 4'(TURN);
  localparam logic [3:0] TURN_LAST = 4'(TURN - 1);

  typedef enum logic [2:0] {
    CPU_OWN,
    SYNC_WAIT,
    TURN_OFF,
    GRANTED,
    TURN_ON
  } state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_next;
  logic [3:0]        turn_cnt, turn_cnt_next;
  logic [NREQ-1:0]   grant_next;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   winner_onehot;
  logic [PTR_W-1:0]  winner_next_ptr;
  logic [2*NREQ-1:0] rotated;
  logic              found;
  int                offset;
  int                win_idx;
  logic              turn_done;
  logic              released;
  logic              revoke;

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [15:0]     tenure;
  logic [NREQ-1:0] blocked;
  logic            timeout_q;

  // A revoked requester stays blocked until its req is seen low once.
  assign revoke      = (state == GRANTED) && cycle_strobe && (tenure == 16'(MAX_HOLD - 1));
  assign eligible    = req & ~blocked;
  assign timeout_err = timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tenure    <= '0;
      blocked   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != GRANTED)
        tenure <= '0;
      else if (cycle_strobe)
        tenure <= tenure + 16'd1;
      blocked <= (blocked & req) | ((revoke && !released) ? grant : '0);
      if (revoke && !released)
        timeout_q <= 1'b1;
    end
  end
`else
  assign revoke      = 1'b0;
  assign eligible    = req;
  assign timeout_err = 1'b0;
`endif

  // Rotate so bit 0 is rr_ptr; the first set bit is the round-robin winner.
  always_comb begin
    rotated         = {eligible, eligible} >> rr_ptr;
    found           = 1'b0;
    offset          = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    win_idx         = (int'(rr_ptr) + offset) % NREQ;
    winner_onehot   = NREQ'(1) << win_idx;
    winner_next_ptr = PTR_W'((win_idx + 1) % NREQ);
  end

  assign turn_done = (turn_cnt >= TURN_LAST);
  assign released  = (state == GRANTED) && ((req & grant) == '0);
  assign busen     = (state == CPU_OWN) || (state == SYNC_WAIT);
  assign bus_idle  = (state == CPU_OWN);

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    rr_ptr_next   = rr_ptr;
    turn_cnt_next = '0;
    case (state)
      CPU_OWN: begin
        if (|eligible)
          state_next = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (!(|eligible))
          state_next = CPU_OWN;
        else if (cycle_strobe && mlock_n)
          state_next = TURN_OFF;
      end
      TURN_OFF, TURN_ON: begin
        if (turn_done) begin
          if (found) begin
            grant_next  = winner_onehot;
            rr_ptr_next = winner_next_ptr;
            state_next  = GRANTED;
          end else begin
            state_next = (state == TURN_OFF) ? TURN_ON : CPU_OWN;
          end
        end else begin
          turn_cnt_next = (turn_cnt < TURN_MAX) ? turn_cnt + 4'd1 : turn_cnt;
        end
      end
      GRANTED: begin
        if (released || revoke) begin
          grant_next = '0;
          state_next = TURN_ON;
        end
      end
      default: begin
        grant_next = '0;
        state_next = CPU_OWN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CPU_OWN;
      grant    <= '0;
      rr_ptr   <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      rr_ptr   <= rr_ptr_next;
      turn_cnt <= turn_cnt_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter (NREQ=2, TURN=2, MAX_HOLD=4)
module tb_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       cycle_strobe;
  logic       mlock_n;
  logic [1:0] req;
  logic [1:0] grant;
  logic       busen;
  logic       bus_idle;
  logic       timeout_err;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic exp_terr = 1'b0;

  typedef struct {
    logic [4:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bus_arbiter #(.NREQ(2), .TURN(2), .MAX_HOLD(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .cycle_strobe (cycle_strobe),
    .mlock_n      (mlock_n),
    .req          (req),
    .grant        (grant),
    .busen        (busen),
    .bus_idle     (bus_idle),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_out();
    exp_t       e;
    logic [4:0] obs;
    obs = {grant, busen, bus_idle, timeout_err};
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d entries, expected at least 1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs === e.vec) else begin
        n_fail++;
        $error("FAIL %s: observed {grant,busen,idle,terr}=%b expected %b", e.tag, obs, e.vec);
      end
    end
    n_cmp++;
    assert (!((grant != 2'b00) && busen) && (grant != 2'b11)) else begin
      n_fail++;
      $error("FAIL invariant: observed grant=%b busen=%b expected exclusive one-hot ownership", grant, busen);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic stb, input logic [1:0] eg,
                      input logic eb, input logic ei, input string tag);
    exp_t e;
    req          = r;
    cycle_strobe = stb;
    e.vec        = {eg, eb, ei, exp_terr};
    e.tag        = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    reset        = 1'b1;
    cycle_strobe = 1'b0;
    mlock_n      = 1'b1;
    req          = 2'b00;
    #1;

    step(2'b00, 0, 2'b00, 1, 1, "reset0");
    step(2'b00, 0, 2'b00, 1, 1, "reset1");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(2'b00, (i % 3) == 0, 2'b00, 1, 1, "idle");

    // Single requester, strobe three clocks after req.
    step(2'b01, 0, 2'b00, 1, 0, "r0_sync");
    step(2'b01, 0, 2'b00, 1, 0, "r0_wait1");
    step(2'b01, 0, 2'b00, 1, 0, "r0_wait2");
    step(2'b01, 1, 2'b00, 0, 0, "r0_busen_fall");
    step(2'b01, 1, 2'b00, 0, 0, "r0_turn_off");
    step(2'b01, 0, 2'b01, 0, 0, "r0_grant");
    step(2'b01, 1, 2'b01, 0, 0, "r0_hold_strobe");
    step(2'b01, 0, 2'b01, 0, 0, "r0_hold");
    step(2'b00, 0, 2'b00, 0, 0, "r0_release");
    step(2'b00, 0, 2'b00, 0, 0, "r0_turn_on");
    step(2'b00, 0, 2'b00, 1, 1, "r0_busen_back");

    // Locked strobes do not qualify.
    step(2'b10, 0, 2'b00, 1, 0, "lk_sync");
    mlock_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1, 2'b00, 1, 0, "lk_locked_strobe");
      step(2'b10, 0, 2'b00, 1, 0, "lk_gap");
    end
    mlock_n = 1'b1;
    step(2'b10, 1, 2'b00, 0, 0, "lk_busen_fall");
    step(2'b10, 0, 2'b00, 0, 0, "lk_turn_off");
    step(2'b10, 0, 2'b10, 0, 0, "lk_grant");
    step(2'b00, 0, 2'b00, 0, 0, "lk_release");
    step(2'b00, 0, 2'b00, 0, 0, "lk_turn_on");
    step(2'b00, 0, 2'b00, 1, 1, "lk_busen_back");

    // Both requesting: rr_ptr=0 so req[0] first, then back-to-back handovers.
    step(2'b11, 0, 2'b00, 1, 0, "rr_sync");
    step(2'b11, 1, 2'b00, 0, 0, "rr_busen_fall");
    step(2'b11, 0, 2'b00, 0, 0, "rr_turn_off");
    step(2'b11, 0, 2'b01, 0, 0, "rr_grant0");
    step(2'b11, 0, 2'b01, 0, 0, "rr_hold0");
    step(2'b10, 0, 2'b00, 0, 0, "rr_release0");
    step(2'b11, 0, 2'b00, 0, 0, "rr_reraise0_turn");
    step(2'b11, 0, 2'b10, 0, 0, "rr_grant1_first");
    step(2'b11, 0, 2'b10, 0, 0, "rr_hold1");
    step(2'b01, 0, 2'b00, 0, 0, "rr_release1");
    step(2'b01, 0, 2'b00, 0, 0, "rr_turn_on1");
    step(2'b01, 0, 2'b01, 0, 0, "rr_grant0_again");
    step(2'b00, 0, 2'b00, 0, 0, "rr_release0_last");
    step(2'b00, 0, 2'b00, 0, 0, "rr_turn_on_last");
    step(2'b00, 0, 2'b00, 1, 1, "rr_busen_back");

    // Request withdrawn while waiting for a strobe.
    step(2'b10, 0, 2'b00, 1, 0, "ab_sync");
    step(2'b00, 1, 2'b00, 1, 1, "ab_abandon");

    // Reset during a tenure.
    step(2'b01, 0, 2'b00, 1, 0, "rs_sync");
    step(2'b01, 1, 2'b00, 0, 0, "rs_busen_fall");
    step(2'b01, 0, 2'b00, 0, 0, "rs_turn_off");
    step(2'b01, 0, 2'b01, 0, 0, "rs_grant");
    reset = 1'b1;
    step(2'b01, 0, 2'b00, 1, 1, "rs_reset_mid_grant");
    reset = 1'b0;
    step(2'b01, 0, 2'b00, 1, 0, "rs_restart_sync");
    step(2'b01, 1, 2'b00, 0, 0, "rs_busen_fall2");
    step(2'b01, 0, 2'b00, 0, 0, "rs_turn_off2");
    step(2'b01, 0, 2'b01, 0, 0, "rs_grant2");
`ifdef BUS_ARBITER_TIMEOUT_EN
    // Tenure overrun: revoked on the 4th strobe while req[0] stays high.
    step(2'b01, 1, 2'b01, 0, 0, "to_strobe1");
    step(2'b01, 0, 2'b01, 0, 0, "to_gap");
    step(2'b01, 1, 2'b01, 0, 0, "to_strobe2");
    step(2'b01, 1, 2'b01, 0, 0, "to_strobe3");
    exp_terr = 1'b1;
    step(2'b01, 1, 2'b00, 0, 0, "to_revoke");
    step(2'b01, 0, 2'b00, 0, 0, "to_turn_on");
    step(2'b01, 0, 2'b00, 1, 1, "to_cpu_back");
    for (int i = 0; i < 4; i++) step(2'b01, 1, 2'b00, 1, 1, "to_no_regrant");
    step(2'b00, 0, 2'b00, 1, 1, "to_req_low");
    step(2'b01, 0, 2'b00, 1, 0, "to_resync");
    step(2'b01, 1, 2'b00, 0, 0, "to_busen_fall");
    step(2'b01, 0, 2'b00, 0, 0, "to_turn_off");
    step(2'b01, 0, 2'b01, 0, 0, "to_regrant");
`else
    for (int i = 0; i < 6; i++) step(2'b01, 1, 2'b01, 0, 0, "unbounded_hold");
`endif
    step(2'b00, 0, 2'b00, 0, 0, "end_release");
    step(2'b00, 0, 2'b00, 0, 0, "end_turn_on");
    step(2'b00, 0, 2'b00, 1, 1, "end_busen_back");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the 6502 system bus (addr/data/rw) between the CPU and up to NREQ bus-master requesters, such as the flash boot loader and a future DMA engine.
- Controls the CPU BE line (busen). It hands the bus over only at CPU cycle boundaries, never inside a locked (ML) sequence, and inserts turnaround gaps so two drivers never overlap.
- Sits in the top level between the requesters and the shared addr/data/rw tri-state enables.

Parameters:
- NREQ, 2, number of requesters (1..8).
- TURN, 2, turnaround gap in clock cycles between one driver releasing the bus and the next being enabled (1..15).
- MAX_HOLD, 1024, maximum tenure in cycle_strobe counts before forced revoke (used only with the optional feature).

Ports:
- clock, input, 1, system clock; single clock domain.
- reset, input, 1, synchronous, active-high.
- cycle_strobe, input, 1, one-clock pulse marking the end of a CPU bus cycle.
- mlock_n, input, 1, CPU memory lock, active-low; handover is forbidden while it is low.
- req, input, NREQ, per-requester bus request, level; held high for the whole tenure.
- grant, output, NREQ, one-hot bus grant; the requester may drive the bus only while its bit is high.
- busen, output, 1, CPU bus enable (BE); 1 = the CPU drives the bus.
- bus_idle, output, 1, high when the CPU owns the bus and no handover is in progress.
- timeout_err, output, 1, sticky tenure-overrun flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: busen=1, grant=0, bus_idle=1, timeout_err=0.
  - Internal: state=CPU_OWN, rr_ptr=0, turn counter=0.
  - Reset asserted in any state returns to these values on the next clock edge. A granted requester loses its grant immediately; no turnaround is applied.
- States:
  - CPU_OWN: busen=1, bus_idle=1. If any req bit is high, go to SYNC_WAIT.
  - SYNC_WAIT: busen=1, bus_idle=0.
    - On a clock where cycle_strobe=1 and mlock_n=1: set busen=0 on the next edge and go to TURN_OFF.
    - If all req bits drop before that: return to CPU_OWN.
  - TURN_OFF: busen=0. Count TURN clocks. At the end, pick the winner by round-robin and go to GRANTED with that grant bit high.
    - If no req is pending at that point, go to TURN_ON instead.
  - GRANTED: exactly one grant bit is high. When that requester's req drops, clear grant on the next edge and go to TURN_ON.
  - TURN_ON: grant=0, busen=0. Count TURN clocks. Then:
    - if any req is pending, do round-robin selection and go straight to GRANTED (back-to-back handover without returning the bus to the CPU);
    - otherwise set busen=1 and go to CPU_OWN.
- Round-robin rule:
  - Search starts at rr_ptr and increments modulo NREQ; the first high req bit wins.
  - After each grant, rr_ptr = winner+1 mod NREQ.
  - If the granted requester deasserts and reasserts req, it does not regain the bus ahead of other pending requesters.
- Latency:
  - From req rising in CPU_OWN to grant: 1 clock to SYNC_WAIT, then a wait for a qualifying strobe, then 1 clock for busen to fall, then TURN clocks.
  - Minimum latency is TURN+2 clocks when the strobe is already present.
- Invariants:
  - grant is never nonzero while busen=1.
  - At least TURN clocks always separate busen falling and any grant rising.
  - At least TURN clocks always separate grant falling and busen rising or a new grant rising.
  - grant is always one-hot or zero.
- Edge cases:
  - A req bit that is not granted and drops while pending is ignored.
  - Strobes arriving during TURN_OFF, TURN_ON or GRANTED are ignored.
  - A strobe seen while mlock_n=0 does not qualify; keep waiting.
  - req changes during TURN_OFF are re-sampled at selection time.
  - The turn counter is 4 bits wide and saturates at TURN.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A 16-bit tenure counter clears when entering GRANTED and increments on each cycle_strobe while in GRANTED.
  - When it reaches MAX_HOLD, grant is forced to 0 and the state moves to TURN_ON, exactly as for a normal release. timeout_err is set to 1 and stays high until reset.
  - The revoked requester is not re-granted until its req has been observed low for at least one clock.
- Undefined: no tenure counter; timeout_err is tied to 0 and tenure is unbounded.

Test Plan:
- Reset, then idle for 20 clocks with req=00 -> busen=1, grant=00, bus_idle=1 throughout.
- TURN=2; req=01 raised, strobe 3 clocks later with mlock_n=1 -> busen falls 1 clock after the strobe, grant=01 exactly 2 clocks after busen falls. Drop req -> grant=00 the next clock, busen=1 exactly 2 clocks later.
- mlock_n=0 across 3 strobes with req=10, then mlock_n=1 on the 4th strobe -> busen stays 1 until the 4th strobe, then the normal grant sequence with grant=10.
- req=11 from CPU_OWN -> grant=01 first. Release req[0] and keep req[1] high -> grant=10 after TURN clocks while busen stays 0. Then re-raise req[0] during req[1]'s tenure and release req[1] -> grant=01. Release req[0] with no requests pending -> busen returns to 1 after TURN clocks.
- Reset asserted mid-GRANTED (grant=01) -> next edge: grant=00, busen=1, state CPU_OWN. A req still high restarts the full SYNC_WAIT sequence.
- With BUS_ARBITER_TIMEOUT_EN and MAX_HOLD=4: req=01 held high forever -> grant revoked after the 4th strobe in GRANTED, timeout_err=1, and no re-grant while req[0] stays high. Drop req[0] for 1 clock and re-raise -> granted again.
